// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target block.
//   state_t         : frame-level FSM states
//   TX_FILL_DEFAULT : byte shifted out when no transmit data is held
//   mode_t          : SPI mode captured at chip-select assertion
package spi_target_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  localparam logic [7:0] TX_FILL_DEFAULT = 8'hFF;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;

endpackage

// File: rtl/spi_target_sync.sv
// Pad-input synchronizer with registered edge detection.
//   clk_i, rst_ni : system clock, async active-low reset
//   pad           : asynchronous pad input
//   level         : synchronized level (SYNC_STAGES flops deep, minimum 2)
//   rise, fall    : single-cycle pulses on synchronized level changes
module spi_target_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {SYNC_STAGES{RST_VAL}};
      level_q <= RST_VAL;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad};
      level_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_q;
  assign fall  = ~level & level_q;

endmodule

// File: rtl/spi_target.sv
// SPI target (slave) oversampled in the clk_i domain.
//   clk_i, rst_ni          : system clock (>= 8x SCLK), async active-low reset
//   cpol_i, cpha_i         : SPI mode, captured when cs_n falls
//   i_sclk, i_cs_n, i_mosi : pad inputs from the master
//   o_miso, o_miso_oen     : pad output, oen low = drive
//   rx_data_o/rx_valid_o/rx_ready_i : received byte stream
//   tx_data_i/tx_valid_i/tx_ready_o : one-entry transmit holding register
//   busy_o                 : frame in progress
//   rx_overrun_o, tx_underrun_o, err_clr_i : sticky error flags and clear
//
// state     | meaning
// WAIT_IDLE | after reset; wait for cs_n high so a live frame is not joined
// IDLE      | cs_n high, pad tristated, waiting for cs_n fall
// ACTIVE    | frame in progress, sampling mosi and shifting miso
module spi_target
  import spi_target_pkg::*;
#(
  parameter int                 DATA_W      = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  TX_FILL     = TX_FILL_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oen,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              busy_o,
  output logic              rx_overrun_o,
  output logic              tx_underrun_o,
  input  logic              err_clr_i
);

  localparam int                CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise_unused, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .pad    (i_sclk),
    .level  (sclk_level_unused),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  // Reset to "selected" so that WAIT_IDLE only leaves once the pad really
  // shows cs_n high, not on the flop reset value.
  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .pad    (i_cs_n),
    .level  (cs_level),
    .rise   (cs_rise_unused),
    .fall   (cs_fall)
  );

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .pad    (i_mosi),
    .level  (mosi_level),
    .rise   (mosi_rise_unused),
    .fall   (mosi_fall_unused)
  );

  state_t             state;
  mode_t              mode;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  tx_shift;
  logic [DATA_W-2:0]  rx_shift;
  logic [DATA_W-1:0]  hold_data;
  logic               hold_full;
  logic               load_pending;  // next load-edge reloads tx_shift (byte boundary)
  logic               skip_shift;    // CPHA=1: first leading edge of a frame only drives

  logic               lead, trail;
  logic               do_sample, do_load, do_shift;
  logic               byte_done, rx_drop, tx_accept;
  logic [DATA_W-1:0]  rx_next, load_value;

  always_comb begin
    lead      = mode.cpol ? sclk_fall : sclk_rise;
    trail     = mode.cpol ? sclk_rise : sclk_fall;
    do_sample = 1'b0;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    case (state)
      IDLE: do_load = cs_fall;
      ACTIVE: begin
        if (!cs_level) begin
          if (!mode.cpha) begin
            do_sample = lead;
            do_load   = trail & load_pending;
            do_shift  = trail & ~load_pending;
          end else begin
            do_sample = trail;
            do_load   = lead & load_pending;
            do_shift  = lead & ~load_pending & ~skip_shift;
          end
        end
      end
      default: ;
    endcase
  end

  assign rx_next    = {rx_shift, mosi_level};
  assign byte_done  = do_sample & (bit_cnt == LAST_BIT);
  assign rx_drop    = byte_done & rx_valid_o & ~rx_ready_i;
  assign load_value = hold_full ? hold_data : TX_FILL;
  assign tx_accept  = tx_valid_i & ~hold_full;
  assign tx_ready_o = ~hold_full;
  assign o_miso     = tx_shift[DATA_W-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= WAIT_IDLE;
      mode          <= '0;
      bit_cnt       <= '0;
      tx_shift      <= '1;
      rx_shift      <= '0;
      hold_data     <= '0;
      hold_full     <= 1'b0;
      load_pending  <= 1'b0;
      skip_shift    <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      rx_overrun_o  <= 1'b0;
      tx_underrun_o <= 1'b0;
      o_miso_oen    <= 1'b1;
      busy_o        <= 1'b0;
    end else begin
      // Holding register: a load frees it; a write into an empty register
      // in the same cycle as an empty-load is kept for the following byte.
      if (do_load && hold_full) begin
        hold_full <= 1'b0;
      end else if (tx_accept) begin
        hold_full <= 1'b1;
        hold_data <= tx_data_i;
      end

      if (do_load) begin
        tx_shift <= load_value;
      end else if (do_shift) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
      end

      if (do_sample) begin
        rx_shift <= rx_next[DATA_W-2:0];
      end

      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (byte_done && !rx_drop) begin
        rx_data_o  <= rx_next;
        rx_valid_o <= 1'b1;
      end

      if (rx_drop) begin
        rx_overrun_o <= 1'b1;
      end else if (err_clr_i) begin
        rx_overrun_o <= 1'b0;
      end

      if (do_load && !hold_full) begin
        tx_underrun_o <= 1'b1;
      end else if (err_clr_i) begin
        tx_underrun_o <= 1'b0;
      end

      case (state)
        WAIT_IDLE: begin
          if (cs_level) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          bit_cnt <= '0;
          if (cs_fall) begin
            mode.cpol    <= cpol_i;
            mode.cpha    <= cpha_i;
            busy_o       <= 1'b1;
            o_miso_oen   <= 1'b0;
            load_pending <= 1'b0;
            skip_shift   <= 1'b1;
            state        <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_level) begin
            bit_cnt      <= '0;
            load_pending <= 1'b0;
            o_miso_oen   <= 1'b1;
            busy_o       <= 1'b0;
            state        <= IDLE;
          end else begin
            if (do_sample) begin
              if (bit_cnt == LAST_BIT) begin
                bit_cnt      <= '0;
                load_pending <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (do_load) begin
              load_pending <= 1'b0;
            end
            if (lead) begin
              skip_shift <= 1'b0;
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule
